regfile_sweep: RTL and testbench
================================

# regfile_sweep

Parametrised multi-port register file for the CPU datapath with a data-width/depth/read-port generalisation, two write ports, same-cycle write-to-read bypass and a hardware clear sweep after reset. It sits in the decode stage, feeding operands to the ALU and accepting writeback results. A registered debug port exposes any register to the board switch/display logic.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; DEPTH = 2**AW registers
- NR, 2, number of operand read ports (1..4)
- ZERO_R0, 1, when 1 register 0 always reads 0 and ignores writes
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- we0, we1  in  1 each  write enables, ports 0 and 1
- wa0, wa1  in  AW each  write addresses
- wd0, wd1  in  DW each  write data
- ra  in  NR*AW  packed read addresses, port i at bits [i*AW +: AW]
- rd  out  NR*DW  packed read data, port i at bits [i*DW +: DW], combinational
- dbg_addr  in  AW  debug read address
- dbg_data  out  DW  debug read data, registered
- busy  out  1  clear sweep in progress; writes ignored, reads return 0

## Operation
- States: SWEEP, RUN. Sweep pointer ptr (AW bits).
- rst high at an edge: state <= SWEEP, ptr <= 0, dbg_data <= 0; no register cleared on that edge.
- SWEEP, rst low: rf[ptr] <= 0, ptr <= ptr+1; on the edge where ptr == DEPTH-1, state <= RUN. Sweep clears every entry exactly once, DEPTH cycles.
- rst during SWEEP restarts the sweep from ptr 0. rst during RUN discards any pending writes of that cycle.
- busy = (state == SWEEP). During SWEEP: we0/we1 ignored, all rd ports and dbg_data capture 0.
- RUN writes: we0 writes wd0 to rf[wa0]; we1 writes wd1 to rf[wa1]. Both enabled with wa0 == wa1: port 1 wins, port 0 discarded. Writes to address 0 dropped when ZERO_R0 = 1.
- Read port i (RUN): if ZERO_R0 and ra_i == 0 -> 0; else if we1 and wa1 == ra_i -> wd1; else if we0 and wa0 == ra_i -> wd0; else rf[ra_i]. Bypass only in RUN.
- Debug port: dbg_data <= same value read port logic would give for dbg_addr (bypass included) each edge in RUN.
- All addresses are full range; no out-of-range case exists. No arithmetic beyond ptr increment, which never wraps (state exits at DEPTH-1).

## Timing
- Reset values: busy = 1 and dbg_data = 0 from the first edge with rst high; rd = 0 while busy.
- busy falls exactly DEPTH edges after the first edge with rst low (DEPTH = 32 by default).
- Write latency: value visible in rf after the write edge; visible on rd in the same cycle via bypass.
- Read latency: rd 0 cycles (combinational from ra, we, wa, wd, rf); dbg_data 1 cycle.
- Write on the edge where state leaves SWEEP is ignored; first accepted write is on the following edge.
- Critical path: ra compare against wa0/wa1 plus DEPTH:1 mux; no pipelining of rd.

## Test plan
- Reset sweep: preload rf via writes (r5 = 0xDEADBEEF), pulse rst 1 cycle -> busy high for 32 cycles after rst falls, then rd for ra = 5 reads 0x00000000, dbg_addr = 31 gives 0.
- Basic write/read: we0, wa0 = 3, wd0 = 0x12345678 -> next cycle ra port0 = 3 returns 0x12345678; port1 ra = 0 returns 0 despite we0 to wa0 = 0 with wd0 = 0xFFFFFFFF.
- Bypass and conflict: we0 wa0 = 7 wd0 = 0xAAAA0000, we1 wa1 = 7 wd1 = 0x0000BBBB, ra port0 = 7 same cycle -> rd = 0x0000BBBB; next cycle rf[7] = 0x0000BBBB.
- Writes during sweep: we0 wa0 = 9 wd0 = 0x55 while busy -> after sweep, r9 reads 0; rd returns 0 during sweep even with bypass match.
- Mid-sweep reset: assert rst at sweep cycle 10 -> busy stays high, sweep restarts, busy falls 32 edges after rst falls again.
- Parameter sweep: DW = 16, AW = 3, NR = 4, ZERO_R0 = 0 -> sweep 8 cycles, r0 writable (wd0 = 0x00A5 reads back 0x00A5), all four ports read independently; dbg_data lags dbg_addr change by exactly 1 cycle.

Source files
------------

// File: rtl/regfile_sweep.sv
// rtl/regfile_sweep.sv - multi-port register file with write bypass and post-reset clear sweep
module regfile_sweep #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NR      = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    wa0,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd0,
  input  logic [DW-1:0]    wd1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data,
  output logic             busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   rf_q [DEPTH];
  logic [DW-1:0]   rf_d [DEPTH];
  logic [DW-1:0]   dbg_data_q, dbg_data_d;
  logic [DW-1:0]   dbg_rd;
  logic            run;
  logic            wr0_ok, wr1_ok;

  // Operand read with same-cycle forwarding; port 1 takes priority because it
  // also wins the write conflict, so the forwarded value matches what lands in rf.
  function automatic logic [DW-1:0] read_port(
    input logic          run_i,
    input logic [AW-1:0] addr_i,
    input logic [DW-1:0] stored_i,
    input logic          we0_i,
    input logic [AW-1:0] wa0_i,
    input logic [DW-1:0] wd0_i,
    input logic          we1_i,
    input logic [AW-1:0] wa1_i,
    input logic [DW-1:0] wd1_i
  );
    logic [DW-1:0] val;
    if (!run_i) begin
      val = '0;
    end else if ((ZERO_R0 != 0) && (addr_i == '0)) begin
      val = '0;
    end else if (we1_i && (wa1_i == addr_i)) begin
      val = wd1_i;
    end else if (we0_i && (wa0_i == addr_i)) begin
      val = wd0_i;
    end else begin
      val = stored_i;
    end
    return val;
  endfunction

  assign run      = (state_q == RUN);
  assign busy     = (state_q == SWEEP);
  assign dbg_data = dbg_data_q;

  // Register 0 is hard-wired when ZERO_R0 is set, so its writes are dropped.
  assign wr0_ok = we0 && !((ZERO_R0 != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_R0 != 0) && (wa1 == '0));

  for (genvar i = 0; i < NR; i++) begin : g_rd
    assign rd[i*DW +: DW] = read_port(run, ra[i*AW +: AW], rf_q[ra[i*AW +: AW]],
                                      we0, wa0, wd0, we1, wa1, wd1);
  end

  assign dbg_rd = read_port(run, dbg_addr, rf_q[dbg_addr],
                            we0, wa0, wd0, we1, wa1, wd1);

  // Next-state: reset restarts the sweep, the sweep clears one entry per cycle,
  // and RUN applies writeback with port 1 overriding port 0 on an address clash.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rf_d       = rf_q;
    dbg_data_d = dbg_data_q;
    if (rst) begin
      state_d    = SWEEP;
      ptr_d      = '0;
      dbg_data_d = '0;
    end else if (state_q == SWEEP) begin
      rf_d[ptr_q] = '0;
      dbg_data_d  = '0;
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else begin
      dbg_data_d = dbg_rd;
      if (wr0_ok) begin
        rf_d[wa0] = wd0;
      end
      if (wr1_ok) begin
        rf_d[wa1] = wd1;
      end
    end
  end

  // State, sweep pointer, storage and debug register update on the rising edge.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    ptr_q      <= ptr_d;
    rf_q       <= rf_d;
    dbg_data_q <= dbg_data_d;
  end

endmodule

// File: tb/tb_regfile_sweep.sv
// tb/tb_regfile_sweep.sv - scoreboard bench for regfile_sweep, default and small configurations
module tb_regfile_sweep;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        we0_s [2];
  logic        we1_s [2];
  logic [4:0]  wa0_s [2];
  logic [4:0]  wa1_s [2];
  logic [31:0] wd0_s [2];
  logic [31:0] wd1_s [2];
  logic [4:0]  ra_s  [2][4];
  logic [4:0]  dbg_s [2];

  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [31:0] dbg_a;
  logic [15:0] dbg_b;
  logic        busy_a, busy_b;

  regfile_sweep #(.DW(32), .AW(5), .NR(2), .ZERO_R0(1)) u_a (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0_s[0]),
    .we1      (we1_s[0]),
    .wa0      (wa0_s[0]),
    .wa1      (wa1_s[0]),
    .wd0      (wd0_s[0]),
    .wd1      (wd1_s[0]),
    .ra       ({ra_s[0][1], ra_s[0][0]}),
    .rd       (rd_a),
    .dbg_addr (dbg_s[0]),
    .dbg_data (dbg_a),
    .busy     (busy_a)
  );

  regfile_sweep #(.DW(16), .AW(3), .NR(4), .ZERO_R0(0)) u_b (
    .clk      (clk),
    .rst      (rst),
    .we0      (we0_s[1]),
    .we1      (we1_s[1]),
    .wa0      (wa0_s[1][2:0]),
    .wa1      (wa1_s[1][2:0]),
    .wd0      (wd0_s[1][15:0]),
    .wd1      (wd1_s[1][15:0]),
    .ra       ({ra_s[1][3][2:0], ra_s[1][2][2:0], ra_s[1][1][2:0], ra_s[1][0][2:0]}),
    .rd       (rd_b),
    .dbg_addr (dbg_s[1][2:0]),
    .dbg_data (dbg_b),
    .busy     (busy_b)
  );

  // Reference model: per instance, storage contents plus cycles of sweep left.
  logic [31:0] mem [2][32];
  int          sweep_left [2];
  logic [31:0] dbg_exp [2];
  bit          known = 1'b0;

  typedef struct packed {
    logic             inst;
    logic             busy;
    logic [3:0][31:0] rd;
    logic [31:0]      dbg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int aw_of(int k);
    return (k == 0) ? 5 : 3;
  endfunction
  function automatic int nr_of(int k);
    return (k == 0) ? 2 : 4;
  endfunction
  function automatic bit zr_of(int k);
    return (k == 0);
  endfunction
  function automatic logic [31:0] dmask(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] model_read(int k, logic [4:0] a);
    if (sweep_left[k] > 0) return '0;
    if (zr_of(k) && a == 5'd0) return '0;
    if (we1_s[k] && wa1_s[k] == a) return wd1_s[k];
    if (we0_s[k] && wa0_s[k] == a) return wd0_s[k];
    return mem[k][a];
  endfunction

  task automatic push_all();
    exp_t e;
    if (!known) return;
    for (int k = 0; k < 2; k++) begin
      e.inst = k[0];
      e.busy = (sweep_left[k] > 0);
      for (int p = 0; p < 4; p++) e.rd[p] = model_read(k, ra_s[k][p]);
      e.dbg = dbg_exp[k];
      q.push_back(e);
    end
  endtask

  task automatic update_all();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sweep_left[k] = 1 << aw_of(k);
        dbg_exp[k]    = '0;
      end else if (sweep_left[k] > 0) begin
        dbg_exp[k]    = '0;
        sweep_left[k] = sweep_left[k] - 1;
        if (sweep_left[k] == 0)
          for (int i = 0; i < 32; i++) mem[k][i] = '0;
      end else begin
        dbg_exp[k] = model_read(k, dbg_s[k]);
        if (we0_s[k] && !(zr_of(k) && wa0_s[k] == 5'd0)) mem[k][wa0_s[k]] = wd0_s[k];
        if (we1_s[k] && !(zr_of(k) && wa1_s[k] == 5'd0)) mem[k][wa1_s[k]] = wd1_s[k];
      end
    end
    if (rst) known = 1'b1;
  endtask

  // Inputs are already applied at the falling edge; record expectations, clock, advance model.
  task automatic step();
    push_all();
    @(posedge clk);
    update_all();
    @(negedge clk);
  endtask

  task automatic idle(int k);
    we0_s[k] = 1'b0; we1_s[k] = 1'b0;
    wa0_s[k] = '0;   wa1_s[k] = '0;
    wd0_s[k] = '0;   wd1_s[k] = '0;
    for (int p = 0; p < 4; p++) ra_s[k][p] = '0;
    dbg_s[k] = '0;
  endtask

  task automatic rnd(int k);
    int top;
    top = (1 << aw_of(k)) - 1;
    we0_s[k] = 1'($urandom_range(0, 1));
    we1_s[k] = 1'($urandom_range(0, 1));
    wa0_s[k] = 5'($urandom_range(0, top));
    wa1_s[k] = ($urandom_range(0, 3) == 0) ? wa0_s[k] : 5'($urandom_range(0, top));
    wd0_s[k] = $urandom & dmask(k);
    wd1_s[k] = $urandom & dmask(k);
    for (int p = 0; p < 4; p++) begin
      case ($urandom_range(0, 5))
        0:       ra_s[k][p] = wa0_s[k];
        1:       ra_s[k][p] = wa1_s[k];
        default: ra_s[k][p] = 5'($urandom_range(0, top));
      endcase
    end
    dbg_s[k] = 5'($urandom_range(0, top));
  endtask

  task automatic rnd_cycles(int n);
    for (int i = 0; i < n; i++) begin
      rnd(0); rnd(1);
      step();
    end
  endtask

  task automatic check(string name, int k, int p, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d port=%0d t=%0t got=%h expected=%h", name, k, p, $time, act, exp);
    end
  endtask

  // Monitor: drain the scoreboard shortly after each falling edge, once outputs settle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("busy", int'(e.inst), 0, {31'd0, (e.inst ? busy_b : busy_a)}, {31'd0, e.busy});
        for (int p = 0; p < nr_of(int'(e.inst)); p++) begin
          act = e.inst ? {16'h0, rd_b[p*16 +: 16]} : rd_a[p*32 +: 32];
          check("rd", int'(e.inst), p, act, e.rd[p]);
        end
        act = e.inst ? {16'h0, dbg_b} : dbg_a;
        check("dbg_data", int'(e.inst), 0, act, e.dbg);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle(0); idle(1);
    @(negedge clk);
    step(); step();

    // First sweep with stray writes and bypass-matching reads that must be ignored.
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rnd(0); rnd(1);
      if (i == 3) begin
        we0_s[0] = 1'b1; wa0_s[0] = 5'd9; wd0_s[0] = 32'h55; ra_s[0][0] = 5'd9;
      end
      if (i == 31 || i == 32) begin
        we0_s[0] = 1'b1; wa0_s[0] = 5'd9; wd0_s[0] = 32'h77;
      end
      step();
    end
    idle(0); idle(1);
    ra_s[0][0] = 5'd9;
    step();

    // Directed writes, zero register, bypass and port conflict.
    idle(0); idle(1);
    we0_s[0] = 1'b1; wa0_s[0] = 5'd5; wd0_s[0] = 32'hDEADBEEF;
    we0_s[1] = 1'b1; wa0_s[1] = 5'd0; wd0_s[1] = 32'h00A5;
    step();
    idle(0); idle(1);
    we0_s[0] = 1'b1; wa0_s[0] = 5'd3; wd0_s[0] = 32'h12345678;
    we0_s[1] = 1'b1; wa0_s[1] = 5'd1; wd0_s[1] = 32'h1111;
    we1_s[1] = 1'b1; wa1_s[1] = 5'd2; wd1_s[1] = 32'h2222;
    step();
    idle(0); idle(1);
    ra_s[0][0] = 5'd3; ra_s[0][1] = 5'd0; dbg_s[0] = 5'd5;
    we0_s[0] = 1'b1; wa0_s[0] = 5'd0; wd0_s[0] = 32'hFFFFFFFF;
    we0_s[1] = 1'b1; wa0_s[1] = 5'd3; wd0_s[1] = 32'h3333;
    for (int p = 0; p < 4; p++) ra_s[1][p] = 5'(p);
    dbg_s[1] = 5'd0;
    step();
    idle(0); idle(1);
    we0_s[0] = 1'b1; wa0_s[0] = 5'd7; wd0_s[0] = 32'hAAAA0000;
    we1_s[0] = 1'b1; wa1_s[0] = 5'd7; wd1_s[0] = 32'h0000BBBB;
    ra_s[0][0] = 5'd7; ra_s[0][1] = 5'd0; dbg_s[0] = 5'd7;
    for (int p = 0; p < 4; p++) ra_s[1][p] = 5'(3 - p);
    dbg_s[1] = 5'd2;
    step();
    idle(0); idle(1);
    ra_s[0][0] = 5'd7; ra_s[0][1] = 5'd5; dbg_s[0] = 5'd3;
    dbg_s[1] = 5'd1;
    step();
    step();

    rnd_cycles(300);

    // Single-cycle reset pulse, then confirm the earlier contents are gone.
    idle(0); idle(1);
    we0_s[0] = 1'b1; wa0_s[0] = 5'd5; wd0_s[0] = 32'hDEADBEEF;
    step();
    rst = 1'b1;
    rnd(0); rnd(1);
    step();
    rst = 1'b0;
    rnd_cycles(33);
    idle(0); idle(1);
    ra_s[0][0] = 5'd5; dbg_s[0] = 5'd31;
    step();
    step();

    // Reset in the middle of a sweep restarts it.
    rst = 1'b1; idle(0); idle(1);
    step();
    rst = 1'b0;
    rnd_cycles(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rnd_cycles(40);

    rnd_cycles(200);

    idle(0); idle(1);
    step();
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
